// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: song entry layout, FSM states, ROM geometry.
package melody_pkg;

   localparam int ROM_DEPTH = 32;
   localparam int ADDR_W = $clog2(ROM_DEPTH);
   localparam logic [3:0] DUR_END = 4'd0;

   typedef struct packed {
      logic [2:0] note;
      logic       rest;
      logic [3:0] dur;
   } entry_t;

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   function automatic logic is_end(entry_t e);
      return e.dur == DUR_END;
   endfunction

endpackage

// File: rtl/melody_seq_if.sv
// Control and oscillator-facing signals of the melody sequencer.
interface melody_seq_if;
   import melody_pkg::*;

   logic              start;
   logic              stop;
   logic              loop;
   logic [2:0]        note;
   logic              gate;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] step;

   modport master (output start, stop, loop, input note, gate, busy, done, step);
   modport slave  (input start, stop, loop, output note, gate, busy, done, step);
endinterface

// File: rtl/melody_rom.sv
// Song table: combinational read, one {note, rest, dur} entry per address; dur = 0 ends the song.
module melody_rom
   import melody_pkg::*;
(
   input  logic [ADDR_W-1:0] addr,
   output entry_t            entry
);

   always_comb begin
      entry = '{note: 3'd0, rest: 1'b0, dur: DUR_END};
      case (addr)
         5'd0:    entry = '{note: 3'd0, rest: 1'b0, dur: 4'd2};
         5'd1:    entry = '{note: 3'd2, rest: 1'b0, dur: 4'd1};
         5'd2:    entry = '{note: 3'd2, rest: 1'b1, dur: 4'd1};
         5'd3:    entry = '{note: 3'd7, rest: 1'b0, dur: 4'd3};
         default: ;
      endcase
   end

endmodule

// File: rtl/melody_seq.sv
// Melody sequencer: walks the song ROM, driving NOTE/GATE for dur*TICK_DIV cycles then GAP_CYC silent cycles.
// Zero-cycle start latency; all outputs registered; STOP has priority over everything.
module melody_seq
   import melody_pkg::*;
#(
   parameter int TICK_DIV = 12_000_000,
   parameter int GAP_CYC  = 120_000
)(
   input logic         clk,
   input logic         rst_n,
   melody_seq_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);

   state_t            state;
   logic [PW-1:0]     presc;
   logic [3:0]        ticks;
   logic [3:0]        dur_q;
   logic [GW-1:0]     gap_cnt;
   logic [2:0]        note_q;
   logic              gate_q;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] step_q;
   logic [ADDR_W-1:0] next_addr;
   entry_t            first_e;
   entry_t            next_e;

   // Two read ports: the entry after the current step, and entry 0 for start/loop restarts.
   assign next_addr = step_q + ADDR_W'(1);

   melody_rom u_rom_first (.addr(ADDR_W'(0)), .entry(first_e));
   melody_rom u_rom_next  (.addr(next_addr),  .entry(next_e));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         presc   <= '0;
         ticks   <= '0;
         dur_q   <= '0;
         gap_cnt <= '0;
         note_q  <= '0;
         gate_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         step_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            state   <= IDLE;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= '0;
            presc   <= '0;
            ticks   <= '0;
            gap_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     if (is_end(first_e)) begin
                        done_q <= 1'b1;
                     end else begin
                        state  <= PLAY;
                        step_q <= '0;
                        note_q <= first_e.note;
                        gate_q <= ~first_e.rest;
                        dur_q  <= first_e.dur;
                        busy_q <= 1'b1;
                        presc  <= '0;
                        ticks  <= '0;
                     end
                  end
               end
               PLAY: begin
                  if (presc == PRESC_LAST) begin
                     presc <= '0;
                     ticks <= ticks + 4'd1;
                     if (ticks == dur_q - 4'd1) begin
                        state   <= GAP;
                        gate_q  <= 1'b0;
                        gap_cnt <= '0;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt <= '0;
                     presc   <= '0;
                     ticks   <= '0;
                     if (!is_end(next_e)) begin
                        state  <= PLAY;
                        step_q <= next_addr;
                        note_q <= next_e.note;
                        gate_q <= ~next_e.rest;
                        dur_q  <= next_e.dur;
                     end else if (bus.loop && !is_end(first_e)) begin
                        state  <= PLAY;
                        step_q <= '0;
                        note_q <= first_e.note;
                        gate_q <= ~first_e.rest;
                        dur_q  <= first_e.dur;
                     end else begin
                        state  <= IDLE;
                        step_q <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.note = note_q;
   assign bus.gate = gate_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.step = step_q;

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: expected per-cycle trace is expanded from the song sheet, then replayed against the DUT.
module tb_melody_seq;
   localparam int TICK_DIV = 4;
   localparam int GAP_CYC  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   melody_seq_if bus_if();

   melody_seq #(.TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int s_note[4] = '{0, 2, 2, 7};
   int s_rest[4] = '{0, 0, 1, 0};
   int s_dur[4]  = '{2, 1, 1, 3};

   // Observation word: {busy, gate, done, note[2:0], step[4:0]}
   logic [10:0] trace[$];

   function automatic logic [10:0] pack(bit busy, bit gate, bit done, int note, int step);
      return {busy, gate, done, 3'(note), 5'(step)};
   endfunction

   function automatic logic [10:0] obs();
      return {bus_if.busy, bus_if.gate, bus_if.done, bus_if.note, bus_if.step};
   endfunction

   task automatic check(input string tag, input logic [10:0] exp);
      logic [10:0] got;
      got = obs();
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Caller raises start before calling; the first edge inside begins playback.
   task automatic run(input bit loop_v, input int stop_at, input int poke, input bit chain, input string tag);
      bus_if.loop = loop_v;
      for (int c = 0; c < trace.size(); c++) begin
         @(posedge clk); #1;
         bus_if.start = (c == poke);
         check($sformatf("%s_c%0d", tag, c), trace[c]);
         if (c == stop_at) begin
            bus_if.start = 1'b0;
            bus_if.stop  = 1'b1;
            @(posedge clk); #1;
            bus_if.stop = 1'b0;
            check({tag, "_stop"}, pack(0, 0, 0, int'(trace[c][7:5]), 0));
            @(posedge clk); #1;
            check({tag, "_stop_nodone"}, pack(0, 0, 0, int'(trace[c][7:5]), 0));
            return;
         end
      end
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      if (loop_v) begin
         check({tag, "_wrap"}, pack(1, 1, 0, s_note[0], 0));
         bus_if.stop = 1'b1;
         @(posedge clk); #1;
         bus_if.stop = 1'b0;
         check({tag, "_wrap_stop"}, pack(0, 0, 0, s_note[0], 0));
      end else begin
         check({tag, "_done"}, pack(0, 0, 1, s_note[3], 0));
         bus_if.start = chain;
         if (!chain) begin
            @(posedge clk); #1;
            check({tag, "_done_clear"}, pack(0, 0, 0, s_note[3], 0));
         end
      end
   endtask

   initial begin
      bus_if.start = 1'b0;
      bus_if.stop  = 1'b0;
      bus_if.loop  = 1'b0;

      for (int e = 0; e < 4; e++) begin
         for (int i = 0; i < s_dur[e] * TICK_DIV; i++)
            trace.push_back(pack(1, s_rest[e] == 0, 0, s_note[e], e));
         for (int i = 0; i < GAP_CYC; i++)
            trace.push_back(pack(1, 0, 0, s_note[e], e));
      end

      #1 rst_n = 1'b0;
      #2 check("reset", pack(0, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle", pack(0, 0, 0, 0, 0));

      bus_if.start = 1'b1;
      bus_if.stop  = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      bus_if.stop  = 1'b0;
      check("start_and_stop", pack(0, 0, 0, 0, 0));
      @(posedge clk); #1;
      check("still_idle", pack(0, 0, 0, 0, 0));

      bus_if.start = 1'b1;
      run(1'b0, -1, int'($urandom_range(0, 34)), 1'b1, "song");
      run(1'b0, -1, -1, 1'b0, "chained");

      bus_if.start = 1'b1;
      run(1'b1, -1, int'($urandom_range(0, 34)), 1'b0, "loop");

      bus_if.start = 1'b1;
      run(1'b0, 10, -1, 1'b0, "stop10");

      for (int k = 0; k < 4; k++) begin
         bus_if.start = 1'b1;
         run(1'($urandom_range(0, 1)), int'($urandom_range(0, 35)), int'($urandom_range(0, 35)), 1'b0,
             $sformatf("rnd%0d", k));
      end

      bus_if.loop  = 1'b0;
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("async_reset", pack(0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("after_reset", pack(0, 0, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/melody_seq.md
# melody_seq

Melody sequencer that sits directly upstream of the tone oscillator. It steps through a fixed song ROM of {note, rest, duration} entries and drives the oscillator's 3-bit note select on NOTE, together with a GATE that enables the speaker path. Tempo comes from a parameterised tick prescaler, and a fixed articulation gap separates consecutive notes. Control is by START/STOP pulses, with optional looping.

## Interface
Parameters:
- TICK_DIV, 12_000_000: CLK cycles per tempo tick; must be ≥2.
- GAP_CYC, 120_000: CLK cycles of forced silence after each entry; must be ≥1.

Ports:
- CLK  in  1  single system clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  level sampled each cycle; starts playback from step 0 when idle.
- STOP  in  1  aborts playback; wins over START when both are high.
- LOOP  in  1  sampled at the end marker; 1 = restart at step 0.
- NOTE  out  3  note code to the oscillator select (0..7).
- GATE  out  1  1 = oscillator output audible.
- BUSY  out  1  1 while not IDLE.
- DONE  out  1  one-cycle pulse when a non-looping song ends.
- STEP  out  5  current ROM index.

## Operation
- ROM entry is 8 bits: note[2:0], rest (1 bit), dur[3:0] in ticks. dur = 0 is the end marker. Depth is 32, with a combinational read at the STEP address.
- Three states:
  - IDLE: GATE = 0, BUSY = 0.
  - PLAY: the NOTE register is loaded from the entry on entry to the state. GATE = ~rest. Lasts dur × TICK_DIV cycles.
  - GAP: GATE = 0, NOTE held. Lasts GAP_CYC cycles.
- Transitions out of IDLE:
  - IDLE & START & ~STOP → PLAY with STEP = 0.
  - Step 0 holding the end marker → DONE pulse, stay IDLE.
- Transitions out of PLAY:
  - PLAY end → GAP.
- Transitions out of GAP (taken on its last cycle, after STEP is incremented):
  - If entry[STEP+1] is a normal note → PLAY at STEP+1.
  - If it is the end marker and LOOP = 1 → PLAY at STEP = 0.
  - If it is the end marker and LOOP = 0 → IDLE, DONE = 1 for one cycle, STEP = 0.
- STOP in any state → IDLE on the next edge:
  - GATE = 0, STEP = 0, prescaler and gap counter cleared.
  - NOTE holds its last value.
  - No DONE pulse.
- START while BUSY is ignored.
- STEP wraps 31 → 0 if no end marker is present. A song with no end marker loops regardless of LOOP and never asserts DONE.
- Tick prescaler and tick counter reset to 0 on every PLAY entry, so the first tick of every note is full length.
- Default ROM contents (unused entries hold the end marker):
  - 0: note 0, dur 2
  - 1: note 2, dur 1
  - 2: rest, dur 1
  - 3: note 7, dur 3
  - 4: end

## Timing
- Reset values: NOTE = 0, GATE = 0, BUSY = 0, DONE = 0, STEP = 0, state IDLE. Async assert, synchronous deassert is handled externally.
- START sampled high at edge k gives PLAY, BUSY = 1, GATE = 1 and NOTE = entry[0] visible after edge k (0-cycle latency).
- All outputs are registered; none depends combinationally on inputs.
- Prescaler counts 0..TICK_DIV−1. The tick counter compares against dur using a 4-bit counter (max 15 ticks).
- Per-entry length is exactly dur × TICK_DIV + GAP_CYC cycles.
- DONE is asserted in the first IDLE cycle and deasserted the next. A START on that same cycle is accepted.

## Structure
- Package melody_pkg holds:
  - the entry typedef (note, rest, dur fields);
  - the state enum {IDLE, PLAY, GAP};
  - constant DUR_END = 4'd0;
  - constant ROM_DEPTH = 32.
- Sub-module melody_rom: combinational, 5-bit address in, 8-bit entry out. The song data lives only here.
- Top level holds the FSM, prescaler, tick counter, gap counter and output registers.

## Test plan
All scenarios use TICK_DIV = 4, GAP_CYC = 2 and the default ROM.
- Reset mid-PLAY (RST_N low) → all outputs return to their reset values immediately, asynchronously.
- START pulse, LOOP = 0 → the following per-cycle sequence, then DONE on cycle 37 and BUSY = 0:
  - GATE: 8×1, 2×0, 4×1, 2×0, 4×0 (rest), 2×0, 12×1, 2×0;
  - NOTE: 0 / 2 / 2 / 7;
  - total 36 BUSY cycles.
- LOOP = 1 → after the cycle-36 GAP, STEP = 0, NOTE = 0, GATE = 1, no DONE pulse, BUSY stays 1.
- STOP at cycle 10 (in entry 1) → next cycle: IDLE, GATE = 0, STEP = 0, BUSY = 0, NOTE = 2, no DONE.
- START and STOP high together in IDLE → remains IDLE. START during PLAY → STEP and timing unchanged.
